pll_clk_sequencer: RTL and testbench

//  Consumer end of the core PLL (50 MHz ref -> 96 MHz clk_sys, plus its 'locked' flag).

---
 rtl/pll_seq_pkg.sv | 22 ++
 rtl/ce_frac_gen.sv | 48 ++++
 rtl/pll_clk_sequencer.sv | 139 +++++++++++++
 tb/tb_pll_clk_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and default clock-plan constants for the PLL clock sequencer.
// The defaults assume a 96 MHz clk_sys.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } seq_state_e;

    // 1 ms of stable lock at 96 MHz
    localparam int unsigned DEF_LOCK_HOLD = 96000;

    // 96/12 = 8 MHz CPU, 96/24 = 4 MHz sound, 96/16 = 6 MHz pixel
    localparam int unsigned DEF_CPU_NUM = 1;
    localparam int unsigned DEF_CPU_DEN = 12;
    localparam int unsigned DEF_SND_NUM = 1;
    localparam int unsigned DEF_SND_DEN = 24;
    localparam int unsigned DEF_PIX_NUM = 1;
    localparam int unsigned DEF_PIX_DEN = 16;

endpackage

// File: rtl/ce_frac_gen.sv
// Fractional clock-enable generator: averages NUM pulses per DEN cycles while run=1.
// The accumulator is cleared whenever run is low, so the phase restarts on every release.
module ce_frac_gen #(
    parameter int unsigned NUM = 1,
    parameter int unsigned DEN = 12
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic run,
    output logic ce
);

    // Wide enough to hold acc + NUM, which never exceeds DEN + NUM - 1
    localparam int unsigned ACC_W = (DEN + NUM > 2) ? $clog2(DEN + NUM) : 1;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] sum;
    logic             ce_q;
    logic             ce_d;

    always_comb begin
        sum   = acc_q + ACC_W'(NUM);
        acc_d = '0;
        ce_d  = 1'b0;
        if (run) begin
            if (sum >= ACC_W'(DEN)) begin
                acc_d = sum - ACC_W'(DEN);
                ce_d  = 1'b1;
            end else begin
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            acc_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ce_q  <= ce_d;
        end
    end

    assign ce = ce_q;

endmodule

// File: rtl/pll_clk_sequencer.sv
// Sits between the PLL wrapper and the core: filters PLL lock, holds the core in
// reset until lock has been stable for LOCK_HOLD cycles, and generates the core enables.
module pll_clk_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned LOCK_HOLD = DEF_LOCK_HOLD,
    parameter int unsigned CPU_NUM   = DEF_CPU_NUM,
    parameter int unsigned CPU_DEN   = DEF_CPU_DEN,
    parameter int unsigned SND_NUM   = DEF_SND_NUM,
    parameter int unsigned SND_DEN   = DEF_SND_DEN,
    parameter int unsigned PIX_NUM   = DEF_PIX_NUM,
    parameter int unsigned PIX_DEN   = DEF_PIX_DEN
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic pll_locked,
    input  logic pause,
    output logic core_reset,
    output logic ce_cpu,
    output logic ce_snd,
    output logic ce_pix,
    output logic lock_lost
);

    localparam int unsigned CNT_W = (LOCK_HOLD > 2) ? $clog2(LOCK_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_HOLD - 1);

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             meta_q;
    logic             locked_s_q;
    logic             core_reset_q;
    logic             core_reset_d;
    logic             lock_lost_q;
    logic             lock_lost_d;
    logic             run;
    logic             ce_cpu_raw;
    logic             ce_snd_raw;
    logic             ce_pix_raw;

    // Two-flop synchroniser; pll_locked is asynchronous to clk_sys
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            meta_q     <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            meta_q     <= pll_locked;
            locked_s_q <= meta_q;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= WAIT_LOCK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_LOCK: if (locked_s_q) state_d = HOLD;
            HOLD: begin
                if (!locked_s_q) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                end
            end
            RUN:       if (!locked_s_q) state_d = WAIT_LOCK;
            default:   state_d = WAIT_LOCK;
        endcase
    end

    // Hold counter saturates at CNT_LAST and is cleared on any loss of lock
    always_comb begin
        cnt_d        = cnt_q;
        core_reset_d = (state_q != RUN);
        lock_lost_d  = lock_lost_q;
        case (state_q)
            WAIT_LOCK: cnt_d = '0;
            HOLD: begin
                if (!locked_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN:       if (!locked_s_q) lock_lost_d = 1'b1;
            default:   cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt_q        <= '0;
            core_reset_q <= 1'b1;
            lock_lost_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            core_reset_q <= core_reset_d;
            lock_lost_q  <= lock_lost_d;
        end
    end

    assign run = (state_q == RUN);

    ce_frac_gen #(.NUM(CPU_NUM), .DEN(CPU_DEN)) u_ce_cpu (
        .clk_sys (clk_sys),
        .reset   (reset),
        .run     (run),
        .ce      (ce_cpu_raw)
    );

    ce_frac_gen #(.NUM(SND_NUM), .DEN(SND_DEN)) u_ce_snd (
        .clk_sys (clk_sys),
        .reset   (reset),
        .run     (run),
        .ce      (ce_snd_raw)
    );

    ce_frac_gen #(.NUM(PIX_NUM), .DEN(PIX_DEN)) u_ce_pix (
        .clk_sys (clk_sys),
        .reset   (reset),
        .run     (run),
        .ce      (ce_pix_raw)
    );

    // Pause masks only the outputs; accumulators keep their phase
    assign ce_cpu     = ce_cpu_raw & ~pause;
    assign ce_snd     = ce_snd_raw & ~pause;
    assign ce_pix     = ce_pix_raw;
    assign core_reset = core_reset_q;
    assign lock_lost  = lock_lost_q;

endmodule

// File: tb/tb_pll_clk_sequencer.sv
// Directed bench for pll_clk_sequencer with LOCK_HOLD=16, plus a second instance
// running a 2/25 fractional CPU enable.
module tb_pll_clk_sequencer;

    localparam int unsigned LH = 16;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic reset, pll_locked, pause;
    logic core_reset, ce_cpu, ce_snd, ce_pix, lock_lost;
    logic reset_f, locked_f, pause_f;
    logic core_reset_f, ce_cpu_f, ce_snd_f, ce_pix_f, lock_lost_f;

    int n_checks = 0;
    int n_errors = 0;
    int rk;

    pll_clk_sequencer #(.LOCK_HOLD(LH)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .pll_locked (pll_locked),
        .pause      (pause),
        .core_reset (core_reset),
        .ce_cpu     (ce_cpu),
        .ce_snd     (ce_snd),
        .ce_pix     (ce_pix),
        .lock_lost  (lock_lost)
    );

    pll_clk_sequencer #(.LOCK_HOLD(LH), .CPU_NUM(2), .CPU_DEN(25)) dut_frac (
        .clk_sys    (clk_sys),
        .reset      (reset_f),
        .pll_locked (locked_f),
        .pause      (pause_f),
        .core_reset (core_reset_f),
        .ce_cpu     (ce_cpu_f),
        .ce_snd     (ce_snd_f),
        .ce_pix     (ce_pix_f),
        .lock_lost  (lock_lost_f)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    // Counts edges until core_reset falls; expected count is hand-derived per scenario
    task automatic wait_release(input string tag, input int exp_n);
        int n;
        n = 0;
        while (core_reset !== 1'b0 && n < 200) begin
            tick(1);
            n++;
        end
        check(tag, 32'(n), 32'(exp_n));
        rk = 1;
    endtask

    // Reference: the k-th cycle with core_reset=0 carries a pulse when k is a multiple of DEN
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1);
            rk++;
            check($sformatf("ce_cpu@%0d", rk), 32'(ce_cpu), 32'((rk % 12 == 0) && !pause));
            check($sformatf("ce_snd@%0d", rk), 32'(ce_snd), 32'((rk % 24 == 0) && !pause));
            check($sformatf("ce_pix@%0d", rk), 32'(ce_pix), 32'(rk % 16 == 0));
            check($sformatf("core_reset@%0d", rk), 32'(core_reset), 32'(0));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n, cnt, last, gmin, gmax;
        reset = 1'b1; pll_locked = 1'b0; pause = 1'b0;
        reset_f = 1'b1; locked_f = 1'b0; pause_f = 1'b0;
        rk = 0;
        tick(3);
        check("rst_core_reset", 32'(core_reset), 32'(1));
        check("rst_ce_cpu",     32'(ce_cpu),     32'(0));
        check("rst_ce_snd",     32'(ce_snd),     32'(0));
        check("rst_ce_pix",     32'(ce_pix),     32'(0));
        check("rst_lock_lost",  32'(lock_lost),  32'(0));

        reset = 1'b0;
        tick(2);
        check("no_lock_core_reset", 32'(core_reset), 32'(1));

        // One-cycle glitch timed so the synced low lands on HOLD count 10
        pll_locked = 1'b1;
        tick(12);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        wait_release("glitch_release_latency", 20);
        check("release_ce_cpu", 32'(ce_cpu), 32'(0));
        check("release_ce_snd", 32'(ce_snd), 32'(0));
        check("release_ce_pix", 32'(ce_pix), 32'(0));

        run_cycles(96);
        pause = 1'b1;
        run_cycles(100);
        pause = 1'b0;
        run_cycles(60);

        // Lock drop while running
        pll_locked = 1'b0;
        tick(3);
        check("drop_lock_lost", 32'(lock_lost), 32'(1));
        tick(1);
        check("drop_core_reset", 32'(core_reset), 32'(1));
        check("drop_ce_cpu", 32'(ce_cpu), 32'(0));
        check("drop_ce_snd", 32'(ce_snd), 32'(0));
        check("drop_ce_pix", 32'(ce_pix), 32'(0));
        pll_locked = 1'b1;
        wait_release("relock_latency", 20);
        check("relock_lock_lost_sticky", 32'(lock_lost), 32'(1));
        run_cycles(30);

        // Single-cycle reset while running
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midrst_core_reset", 32'(core_reset), 32'(1));
        check("midrst_ce_cpu",     32'(ce_cpu),     32'(0));
        check("midrst_ce_snd",     32'(ce_snd),     32'(0));
        check("midrst_ce_pix",     32'(ce_pix),     32'(0));
        check("midrst_lock_lost",  32'(lock_lost),  32'(0));
        wait_release("midrst_release_latency", 20);
        run_cycles(48);

        // Fractional 2/25 CPU enable on the second instance
        reset_f = 1'b0;
        locked_f = 1'b1;
        n = 0;
        while (core_reset_f !== 1'b0 && n < 200) begin
            tick(1);
            n++;
        end
        check("frac_release_latency", 32'(n), 32'(20));
        cnt = 0; last = 0; gmin = 1000; gmax = 0;
        for (int k = 1; k <= 2500; k++) begin
            tick(1);
            if (ce_cpu_f === 1'b1) begin
                cnt++;
                if (last > 0) begin
                    if (k - last < gmin) gmin = k - last;
                    if (k - last > gmax) gmax = k - last;
                end
                last = k;
            end
        end
        check("frac_pulse_count", 32'(cnt),  32'(200));
        check("frac_gap_min",     32'(gmin), 32'(12));
        check("frac_gap_max",     32'(gmax), 32'(13));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
